// File: rtl/mac_rx_frame_fifo.sv
// Store-and-forward rx frame buffer: only complete, CRC-good frames reach the consumer.
// Optional statistics counters are enabled with the MAC_RX_FIFO_STATS_EN macro.
module mac_rx_frame_fifo #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  rx_user_clk_i,
    input  logic                  rx_user_rst_n_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [1:0]            s_vldb_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    input  logic                  s_user_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            m_vldb_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  drop_o,
`ifdef MAC_RX_FIFO_STATS_EN
    output logic [31:0]           good_cnt_o,
    output logic [31:0]           crc_drop_cnt_o,
    output logic [31:0]           ovf_drop_cnt_o,
`endif
    output logic [ADDR_WIDTH:0]   level_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned WORD_W = DATA_WIDTH + 3;
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {StWrite = 1'b0, StDiscard = 1'b1} wr_state_e;

    wr_state_e wr_state_q, wr_state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] used;
    logic [ADDR_WIDTH:0] level_q;
    logic                full;
    logic                mem_we;
    logic                commit_ev, crc_drop_ev, ovf_drop_ev;
    logic                drop_q;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   ram_q;
    logic                ram_valid_q;
    logic                rd_en;
    logic                avail;
    logic                pop;
    logic [1:0]          occ;

    logic [WORD_W-1:0]   out_q, out_d, skid_q, skid_d;
    logic                out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    // Full uses registered pointers only, so a same-cycle read never frees room for a write.
    assign used = wr_ptr_q - rd_ptr_q;
    assign full = (used == DEPTH_PTR);

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        commit_ev    = 1'b0;
        crc_drop_ev  = 1'b0;
        ovf_drop_ev  = 1'b0;
        case (wr_state_q)
            StWrite: begin
                if (s_valid_i) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_last_i) begin
                            if (s_user_i) begin
                                wr_ptr_d    = commit_ptr_q;
                                crc_drop_ev = 1'b1;
                            end else begin
                                commit_ptr_d = wr_ptr_q + 1'b1;
                                commit_ev    = 1'b1;
                            end
                        end
                    end else begin
                        wr_ptr_d    = commit_ptr_q;
                        ovf_drop_ev = 1'b1;
                        if (!s_last_i) begin
                            wr_state_d = StDiscard;
                        end
                    end
                end
            end
            StDiscard: begin
                if (s_valid_i && s_last_i) begin
                    wr_state_d = StWrite;
                end
            end
            default: wr_state_d = StWrite;
        endcase
    end

    // Read issue is credit-based: skid entries plus the in-flight RAM word never exceed two.
    assign avail = (rd_ptr_q != commit_ptr_q);
    assign pop   = out_valid_q & m_ready_i;

    always_comb begin
        occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(ram_valid_q) - 2'(pop);
        rd_en    = avail && (occ < 2'd2);
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (pop) begin
            out_valid_d  = skid_valid_q;
            out_d        = skid_valid_q ? skid_q : out_q;
            skid_valid_d = 1'b0;
        end
        if (ram_valid_q) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_d       = ram_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = ram_q;
            end
        end
    end

    always_ff @(posedge rx_user_clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_last_i, s_vldb_i, s_data_i};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge rx_user_clk_i) begin
        if (!rx_user_rst_n_i) begin
            wr_state_q   <= StWrite;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_q       <= 1'b0;
            ram_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= wr_ptr_d - rd_ptr_d;
            drop_q       <= crc_drop_ev | ovf_drop_ev;
            ram_valid_q  <= rd_en;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign m_data_o  = out_q[DATA_WIDTH-1:0];
    assign m_vldb_o  = out_q[DATA_WIDTH+1:DATA_WIDTH];
    assign m_last_o  = out_q[DATA_WIDTH+2];
    assign m_valid_o = out_valid_q;
    assign drop_o    = drop_q;
    assign level_o   = level_q;

`ifdef MAC_RX_FIFO_STATS_EN
    logic [31:0] good_cnt_q, crc_cnt_q, ovf_cnt_q;

    always_ff @(posedge rx_user_clk_i) begin
        if (!rx_user_rst_n_i) begin
            good_cnt_q <= '0;
            crc_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (commit_ev && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + 1'b1;
            if (crc_drop_ev && (crc_cnt_q != '1)) crc_cnt_q <= crc_cnt_q + 1'b1;
            if (ovf_drop_ev && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign good_cnt_o     = good_cnt_q;
    assign crc_drop_cnt_o = crc_cnt_q;
    assign ovf_drop_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// Directed bench for mac_rx_frame_fifo with a 64-word buffer; checks latency, drops and ordering.
`timescale 1ns/1ps
module tb_mac_rx_frame_fifo;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   s_data;
    logic [1:0]    s_vldb;
    logic          s_valid, s_last, s_user;
    logic [31:0]   m_data;
    logic [1:0]    m_vldb;
    logic          m_valid, m_last, drop;
    bit            m_ready;
    logic [AW:0]   level;
`ifdef MAC_RX_FIFO_STATS_EN
    logic [31:0]   good_cnt, crc_cnt, ovf_cnt;
`endif

    int            checks, failures;
    logic [34:0]   exp_q[$];
    int            hs_cyc_q[$];
    int            cyc, out_beats, drop_seen;
    int            n_good, n_crc, n_ovf, seed_byte;
    bit            ready_force, rand_mode, prev_stall;
    logic [34:0]   prev_beat;

    mac_rx_frame_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .rx_user_clk_i   (clk),
        .rx_user_rst_n_i (rst_n),
        .s_data_i        (s_data),
        .s_vldb_i        (s_vldb),
        .s_valid_i       (s_valid),
        .s_last_i        (s_last),
        .s_user_i        (s_user),
        .m_data_o        (m_data),
        .m_vldb_o        (m_vldb),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_last_o        (m_last),
        .drop_o          (drop),
`ifdef MAC_RX_FIFO_STATS_EN
        .good_cnt_o      (good_cnt),
        .crc_drop_cnt_o  (crc_cnt),
        .ovf_drop_cnt_o  (ovf_cnt),
`endif
        .level_o         (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Output monitor: ordering, stall stability, drop pulse count.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'(1));
                check("stall_beat", 64'({m_last, m_vldb, m_data}), 64'(prev_beat));
            end
            if (m_valid && m_ready) begin
                out_beats++;
                hs_cyc_q.push_back(cyc);
                check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    check("beat_data", 64'({m_last, m_vldb, m_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_vldb, m_data};
            if (drop) drop_seen++;
        end
    end

    task automatic send_frame(input int nbytes, input bit bad, input bit keep, input bit fin);
        int beats = (nbytes + 3) / 4;
        logic [31:0] w;
        for (int b = 0; b < beats; b++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(seed_byte + 4 * b + k);
            s_valid = 1'b1;
            s_data  = w;
            s_last  = fin && (b == beats - 1);
            s_vldb  = s_last ? 2'(nbytes % 4) : 2'd0;
            s_user  = s_last && bad;
            if (keep) exp_q.push_back({s_last, s_vldb, w});
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        s_vldb  = 2'd0;
        seed_byte += 7;
        if (keep) n_good++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic stats_check(input string tag);
`ifdef MAC_RX_FIFO_STATS_EN
        check({tag, "_good"}, 64'(good_cnt), 64'(n_good));
        check({tag, "_crc"}, 64'(crc_cnt), 64'(n_crc));
        check({tag, "_ovf"}, 64'(ovf_cnt), 64'(n_ovf));
`else
        check({tag, "_level"}, 64'(level), 64'(0));
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, hidx, n;
        rst_n = 1'b0;
        s_data = '0; s_vldb = '0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_data", 64'(m_data), 64'(0));
        check("rst_vldb", 64'(m_vldb), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        rst_n = 1'b1;
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 60-byte frame, 2-cycle latency after good last beat
        base = out_beats; d0 = drop_seen;
        send_frame(60, 1'b0, 1'b1, 1'b1);
        check("lat_e0", 64'(m_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_e1", 64'(m_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_e2", 64'(m_valid), 64'(1));
        drain("t1_drain");
        check("t1_beats", 64'(out_beats - base), 64'(15));
        check("t1_drop", 64'(drop_seen - d0), 64'(0));
        check("t1_level", 64'(level), 64'(0));

        // 61 + 62 bytes back-to-back, contiguous output
        base = out_beats; hidx = hs_cyc_q.size();
        send_frame(61, 1'b0, 1'b1, 1'b1);
        send_frame(62, 1'b0, 1'b1, 1'b1);
        drain("t2_drain");
        check("t2_beats", 64'(out_beats - base), 64'(32));
        if (hs_cyc_q.size() >= hidx + 32)
            check("t2_nogap", 64'(hs_cyc_q[hidx + 31] - hs_cyc_q[hidx]), 64'(31));

        // bad 100-byte frame then good 64-byte frame
        base = out_beats; d0 = drop_seen;
        send_frame(100, 1'b1, 1'b0, 1'b1);
        n_crc++;
        send_frame(64, 1'b0, 1'b1, 1'b1);
        drain("t3_drain");
        check("t3_beats", 64'(out_beats - base), 64'(16));
        check("t3_drop", 64'(drop_seen - d0), 64'(1));
        check("t3_level", 64'(level), 64'(0));

        // exact-depth frame fits; beat arriving while full is dropped
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = out_beats; d0 = drop_seen;
        send_frame(256, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("full_level62", 64'(level), 64'(62));
        check("full_valid", 64'(m_valid), 64'(1));
        send_frame(8, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("full_level64", 64'(level), 64'(64));
        send_frame(4, 1'b0, 1'b0, 1'b1);
        n_ovf++;
        repeat (3) @(posedge clk);
        #1;
        check("full_drop", 64'(drop_seen - d0), 64'(1));
        check("full_level_kept", 64'(level), 64'(64));
        ready_force = 1'b1;
        drain("full_drain");
        check("full_beats", 64'(out_beats - base), 64'(66));
        check("full_level0", 64'(level), 64'(0));

        // 100-beat oversize frame while stalled, then 10-beat good frame
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = out_beats; d0 = drop_seen;
        send_frame(400, 1'b0, 1'b0, 1'b1);
        n_ovf++;
        send_frame(40, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_drop", 64'(drop_seen - d0), 64'(1));
        check("ovf_level", 64'(level), 64'(8));
        check("ovf_none_out", 64'(out_beats - base), 64'(0));
        ready_force = 1'b1;
        drain("ovf_drain");
        check("ovf_beats", 64'(out_beats - base), 64'(10));
        stats_check("stats_pre");

        // reset mid-frame with a stalled committed frame on the output
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(60, 1'b0, 1'b1, 1'b1);
        send_frame(32, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        n_good = 0; n_crc = 0; n_ovf = 0;
        check("rstmid_valid", 64'(m_valid), 64'(0));
        check("rstmid_level", 64'(level), 64'(0));
        @(posedge clk); #1;
        check("rstmid_valid2", 64'(m_valid), 64'(0));
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base = out_beats;
        send_frame(60, 1'b0, 1'b1, 1'b1);
        drain("rstmid_drain");
        check("rstmid_beats", 64'(out_beats - base), 64'(15));

        // 100 frames of 60..159 bytes with random backpressure
        rand_mode = 1'b1;
        d0 = drop_seen;
        for (int f = 0; f < 100; f++) begin
            n = 0;
            while (level > 24 && n < 5000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 5000) check("rand_wait", 64'(level), 64'(24));
            send_frame(60 + f, 1'b0, 1'b1, 1'b1);
        end
        drain("rand_drain");
        check("rand_drop", 64'(drop_seen - d0), 64'(0));
        check("rand_level", 64'(level), 64'(0));
        stats_check("stats_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_rx_frame_fifo.md
Name: mac_rx_frame_fifo

Overview:
- Store-and-forward receive frame buffer placed directly downstream of teng_mac's AXIS rx port, in the rx_user_clk_i domain.
- teng_mac rx has no backpressure, so every input beat is accepted unconditionally.
- A frame becomes visible on the output only after its last beat arrives with a good status.
- Frames flagged bad by the MAC (rx_user on last beat) and frames that overflow the buffer are discarded whole, so the consumer sees only complete, CRC-good frames and may apply backpressure freely.

Parameters:
- ADDR_WIDTH, 11, log2 of buffer depth in 32-bit words (2048 words = 8 KB).
- DATA_WIDTH, 32, data bus width; only 32 supported.

Ports:
- rx_user_clk_i  input  1  user clock; all logic on rising edge.
- rx_user_rst_n_i  input  1  synchronous, active-low reset.
- s_data_i  input  32  frame data from MAC, byte 0 in [7:0].
- s_vldb_i  input  2  valid bytes on last beat; 0 = 4 bytes, 1..3 = 1..3 bytes. Ignored on non-last beats.
- s_valid_i  input  1  input beat valid; always accepted.
- s_last_i  input  1  last beat of frame.
- s_user_i  input  1  on last beat: 1 = frame bad (CRC/code error).
- m_data_o  output  32  output data.
- m_vldb_o  output  2  output valid bytes; same encoding as s_vldb_i.
- m_valid_o  output  1  output beat valid.
- m_ready_i  input  1  consumer ready.
- m_last_o  output  1  output last beat.
- drop_o  output  1  one-cycle pulse per discarded frame.
- level_o  output  ADDR_WIDTH+1  words written and not yet read, including uncommitted words.

Behaviour:
- Storage: RAM of 2^ADDR_WIDTH entries × 35 bits (data, vldb, last).
  - Pointers are ADDR_WIDTH+1 bits with wrap bit.
  - wr_ptr: next write address.
  - commit_ptr: end of the last good frame.
  - rd_ptr: next read address.
- Write FSM states:
  - WRITE (reset state):
    - Beat accepted and buffer not full (wr_ptr − rd_ptr < depth): store beat, wr_ptr+1.
    - Last beat with s_user_i=0: commit_ptr ← wr_ptr+1.
    - Last beat with s_user_i=1: wr_ptr ← commit_ptr, drop_o pulse.
    - Beat arrives while full:
      - Not last: rewind wr_ptr to commit_ptr, pulse drop_o, go to DISCARD.
      - Last: rewind, pulse drop_o, stay in WRITE.
  - DISCARD:
    - Ignore beats.
    - On s_valid_i & s_last_i, return to WRITE. No second drop_o pulse.
- Read side:
  - Data is readable when rd_ptr ≠ commit_ptr.
  - Registered RAM read feeds a 2-entry output skid register.
  - AXIS rule: once m_valid_o=1, outputs stay stable until m_ready_i=1.
  - With m_ready_i held high, sustained throughput is 1 beat/cycle.
- Latency: first beat of a frame appears on m_valid_o exactly 2 cycles after the cycle its good last beat is accepted, if the output path is empty.
- Full boundary: full = (wr_ptr − rd_ptr == depth). A read in the same cycle does not free space for that cycle's write (full evaluated on registered pointers).
- Frame longer than depth: always dropped. Frames arriving afterwards are unaffected.
- Single-beat frame (s_valid_i & s_last_i in first beat): handled normally.
- Simultaneous commit and read of the final committed word: the read completes and the new frame becomes visible next cycle. No beat is lost or duplicated.
- level_o = wr_ptr − rd_ptr, registered.
- Reset values: all pointers 0, FSM = WRITE, m_valid_o=0, m_last_o=0, m_data_o=0, m_vldb_o=0, drop_o=0, level_o=0.
- Reset mid-frame: the partial input frame is lost and any partially output frame is truncated without m_last_o. After reset, the first beat accepted starts a new frame.

Optional Feature:
- Macro: MAC_RX_FIFO_STATS_EN.
- Defined: adds outputs good_cnt_o[31:0], crc_drop_cnt_o[31:0], ovf_drop_cnt_o[31:0].
  - good_cnt_o increments on commit.
  - crc_drop_cnt_o increments on an s_user_i drop.
  - ovf_drop_cnt_o increments on an overflow drop.
  - All are saturating, cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- 60-byte frame (15 beats, last vldb=0, user=0), m_ready_i=1 → identical 15 beats out, first m_valid_o 2 cycles after input last, m_last_o on beat 15, drop_o never high.
- 61-byte frame then 62-byte frame back-to-back → 16 beats out with last vldb=1, then 16 beats with last vldb=2; no gap between frames.
- 100-byte frame with s_user_i=1 on last beat, followed by a good 64-byte frame → only the 64-byte frame is output, drop_o pulses once, level_o returns to 0.
- ADDR_WIDTH=6 (64 words), m_ready_i=0, 100-beat frame then 10-beat good frame → first frame dropped (one drop_o pulse); after m_ready_i=1, exactly 10 beats out.
- 100 frames of 60..159 bytes with m_ready_i toggling pseudo-randomly at 50% → byte-exact match, no beat change while stalled; with MAC_RX_FIFO_STATS_EN, good_cnt_o=100.
- Assert rx_user_rst_n_i=0 for 2 cycles mid-frame → m_valid_o=0 and level_o=0 the cycle after reset; the next 60-byte frame passes intact.
